vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Parametrised VGA timing generator. Merges the horizontal and vertical pixel counters into one block.
- Produces registered sync, blanking and pixel-coordinate signals for the frame renderer and the DAC output stage.
- Timing, sync polarity and counter width are parameters, so one block covers 640x480@60 and other modes.
- Adds a clock-enable input, so the block can run from a faster system clock.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- HSYNC_POL, 0, asserted level of hsync (0 = active-low)
- VSYNC_POL, 0, asserted level of vsync
- COUNT_W, 16, width of the count and coordinate outputs

Ports:
- clk_25MHz  in  1  pixel/system clock
- reset_n  in  1  asynchronous reset, active-low
- pix_en  in  1  pixel-advance enable; tie high when clocked at the pixel rate
- h_count_value  out  COUNT_W  horizontal position, 0..H_TOTAL-1
- v_count_value  out  COUNT_W  vertical position, 0..V_TOTAL-1
- hsync  out  1  horizontal sync, polarity set by HSYNC_POL
- vsync  out  1  vertical sync, polarity set by VSYNC_POL
- video_on  out  1  high inside the active region
- line_end  out  1  one-cycle pulse when h_count_value = H_TOTAL-1 and pix_en = 1
- frame_start  out  1  one-cycle pulse on the first enabled cycle of position (0,0)

Behaviour:
- Derived constants: H_TOTAL = H_ACTIVE+H_FRONT+H_SYNC+H_BACK (800); V_TOTAL = V_ACTIVE+V_FRONT+V_SYNC+V_BACK (525).
- Reset (async assert, sync release): h = 0, v = 0, video_on = 1, hsync = ~HSYNC_POL, vsync = ~VSYNC_POL, line_end = 0, frame_start = 0.
- First cycle after release with pix_en = 1: counters advance to (1,0). frame_start is not pulsed for the reset position.
- pix_en = 0: counters and all level outputs hold; line_end and frame_start are 0.
- pix_en = 1, horizontal: h < H_TOTAL-1 gives h+1; otherwise h wraps to 0.
- pix_en = 1, vertical: on h wrap, v < V_TOTAL-1 gives v+1; otherwise v wraps to 0. v changes only on the cycle h wraps.
- Level outputs are registered and computed from the next counter values, so on every cycle they match the h/v values presented. Latency from count to decode is zero.
- hsync asserted iff H_ACTIVE+H_FRONT <= h < H_ACTIVE+H_FRONT+H_SYNC (656..751).
- vsync asserted iff V_ACTIVE+V_FRONT <= v < V_ACTIVE+V_FRONT+V_SYNC (490..491).
- video_on = (h < H_ACTIVE) && (v < V_ACTIVE).
- line_end: registered pulse, one cycle, on the cycle the counter presents H_TOTAL-1 with pix_en = 1.
- frame_start: registered pulse, one cycle, on the cycle (0,0) is presented after a wrap from (H_TOTAL-1, V_TOTAL-1).
- Simultaneous wrap: at (799,524) with pix_en = 1, both counters go to 0 together and frame_start = 1 on the next cycle.
- Reset mid-frame: immediate return to reset values, with no partial sync pulse held.
- Elaboration check: fail (fatal) if H_TOTAL or V_TOTAL exceeds 2**COUNT_W-1, or if any timing parameter is 0.
- Arithmetic is unsigned, COUNT_W bits. Comparisons use constants sized to COUNT_W.

Decomposition:
- Package vga_timing_pkg holds the default 640x480@60 constants (H_/V_ ACTIVE, FRONT, SYNC, BACK), a typedef vga_mode_t struct grouping them, and the COUNT_W default.
- One sub-module, vga_axis_counter: a parametrised wrap counter with enable input, wrap-pulse output and TOTAL parameter.
- vga_axis_counter is instantiated twice. The vertical instance is enabled by the horizontal wrap ANDed with pix_en.
- Sync and blank decode stays in the top level.

Test Plan:
- Reset then pix_en = 1 for 800 cycles -> h runs 0..799, then 0; v goes 0 to 1 exactly at the wrap; line_end is high one cycle at h = 799.
- Full frame of 420000 cycles -> hsync is low for h 656..751 on every line; vsync is low for v 490..491 only; video_on is high for exactly 307200 cycles; frame_start pulses once, at (0,0).
- pix_en toggled 1/0 alternately -> counters advance every other cycle; one frame takes 840000 cycles; no pulse appears on a pix_en = 0 cycle.
- Assert reset_n = 0 asynchronously at (700,300) -> outputs take reset values immediately, without waiting for a clock edge; after release, counting resumes from (0,0).
- HSYNC_POL = 1, VSYNC_POL = 1 -> sync outputs are inverted relative to the default run; all counts are identical.
- Small mode, H_ACTIVE=4, H_FRONT=H_SYNC=H_BACK=1, V_ACTIVE=2, V_FRONT=V_SYNC=V_BACK=1 -> H_TOTAL = 7, V_TOTAL = 5; frame_start period is 35 enabled cycles; hsync is asserted at h = 5 only.

Source files
------------

// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
// vga_timing_pkg : default 640x480@60 timing constants and mode record. rev 1.0
// ============================================================================
package vga_timing_pkg;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FRONT  = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BACK   = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FRONT  = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BACK   = 33;
  localparam int unsigned DEF_COUNT_W  = 16;

  typedef struct packed {
    int unsigned h_active;
    int unsigned h_front;
    int unsigned h_sync;
    int unsigned h_back;
    int unsigned v_active;
    int unsigned v_front;
    int unsigned v_sync;
    int unsigned v_back;
  } vga_mode_t;

  localparam vga_mode_t VGA_640X480_60 = '{
    h_active: DEF_H_ACTIVE, h_front: DEF_H_FRONT, h_sync: DEF_H_SYNC, h_back: DEF_H_BACK,
    v_active: DEF_V_ACTIVE, v_front: DEF_V_FRONT, v_sync: DEF_V_SYNC, v_back: DEF_V_BACK
  };

  function automatic int unsigned mode_h_total(input vga_mode_t m);
    return m.h_active + m.h_front + m.h_sync + m.h_back;
  endfunction

  function automatic int unsigned mode_v_total(input vga_mode_t m);
    return m.v_active + m.v_front + m.v_sync + m.v_back;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_timing_gen_if.sv
`default_nettype none
// ============================================================================
// vga_timing_gen_if : pixel-enable in, counters/sync/blank/pulses out. rev 1.0
// ============================================================================
interface vga_timing_gen_if
  import vga_timing_pkg::*;
#(
  parameter int unsigned COUNT_W = DEF_COUNT_W
);
  logic               pix_en;
  logic [COUNT_W-1:0] h_count_value;
  logic [COUNT_W-1:0] v_count_value;
  logic               hsync;
  logic               vsync;
  logic               video_on;
  logic               line_end;
  logic               frame_start;

  modport master (
    input  pix_en,
    output h_count_value, v_count_value, hsync, vsync, video_on, line_end, frame_start
  );

  modport slave (
    output pix_en,
    input  h_count_value, v_count_value, hsync, vsync, video_on, line_end, frame_start
  );
endinterface
`default_nettype wire

// File: rtl/vga_axis_counter.sv
`default_nettype none
// ============================================================================
// vga_axis_counter : enabled 0..TOTAL-1 wrap counter with next-value output. rev 1.0
// ============================================================================
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned TOTAL   = DEF_H_ACTIVE,
  parameter int unsigned COUNT_W = DEF_COUNT_W
) (
  input  wire logic               clk_i,
  input  wire logic               rst_n_i,
  input  wire logic               en_i,
  output logic      [COUNT_W-1:0] count_o,
  output logic      [COUNT_W-1:0] count_next_o,
  output logic                    wrap_o
);

  localparam logic [COUNT_W-1:0] LAST = COUNT_W'(TOTAL - 1);

  logic [COUNT_W-1:0] count_q;
  logic [COUNT_W-1:0] count_d;
  logic               at_last;

  assign at_last = (count_q == LAST);
  assign wrap_o  = en_i && at_last;

  always_comb begin
    count_d = count_q;
    if (en_i) begin
      count_d = at_last ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o      = count_q;
  assign count_next_o = count_d;

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// vga_timing_gen : parametrised VGA h/v counters with registered sync/blank. rev 1.0
// ============================================================================
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE  = DEF_H_ACTIVE,
  parameter int unsigned H_FRONT   = DEF_H_FRONT,
  parameter int unsigned H_SYNC    = DEF_H_SYNC,
  parameter int unsigned H_BACK    = DEF_H_BACK,
  parameter int unsigned V_ACTIVE  = DEF_V_ACTIVE,
  parameter int unsigned V_FRONT   = DEF_V_FRONT,
  parameter int unsigned V_SYNC    = DEF_V_SYNC,
  parameter int unsigned V_BACK    = DEF_V_BACK,
  parameter bit          HSYNC_POL = 1'b0,
  parameter bit          VSYNC_POL = 1'b0,
  parameter int unsigned COUNT_W   = DEF_COUNT_W
) (
  input wire logic          clk_25MHz,
  input wire logic          reset_n,
  vga_timing_gen_if.master  vga
);

  localparam int unsigned     H_TOTAL   = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned     V_TOTAL   = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam longint unsigned COUNT_MAX = (64'd1 << COUNT_W) - 64'd1;

  localparam logic [COUNT_W-1:0] H_ACT    = COUNT_W'(H_ACTIVE);
  localparam logic [COUNT_W-1:0] V_ACT    = COUNT_W'(V_ACTIVE);
  localparam logic [COUNT_W-1:0] HS_START = COUNT_W'(H_ACTIVE + H_FRONT);
  localparam logic [COUNT_W-1:0] HS_END   = COUNT_W'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [COUNT_W-1:0] VS_START = COUNT_W'(V_ACTIVE + V_FRONT);
  localparam logic [COUNT_W-1:0] VS_END   = COUNT_W'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam logic [COUNT_W-1:0] H_LAST   = COUNT_W'(H_TOTAL - 1);

  if ((longint'(H_TOTAL) > COUNT_MAX) || (longint'(V_TOTAL) > COUNT_MAX)) begin : g_bad_total
    $fatal(1, "vga_timing_gen: H_TOTAL/V_TOTAL do not fit in COUNT_W bits");
  end

  if ((H_ACTIVE == 0) || (H_FRONT == 0) || (H_SYNC == 0) || (H_BACK == 0) ||
      (V_ACTIVE == 0) || (V_FRONT == 0) || (V_SYNC == 0) || (V_BACK == 0)) begin : g_bad_timing
    $fatal(1, "vga_timing_gen: timing parameters must all be non-zero");
  end

  logic [COUNT_W-1:0] h_q;
  logic [COUNT_W-1:0] h_next;
  logic [COUNT_W-1:0] v_q;
  logic [COUNT_W-1:0] v_next;
  logic               h_wrap;
  logic               v_wrap;

  vga_axis_counter #(
    .TOTAL   (H_TOTAL),
    .COUNT_W (COUNT_W)
  ) u_h_counter (
    .clk_i        (clk_25MHz),
    .rst_n_i      (reset_n),
    .en_i         (vga.pix_en),
    .count_o      (h_q),
    .count_next_o (h_next),
    .wrap_o       (h_wrap)
  );

  vga_axis_counter #(
    .TOTAL   (V_TOTAL),
    .COUNT_W (COUNT_W)
  ) u_v_counter (
    .clk_i        (clk_25MHz),
    .rst_n_i      (reset_n),
    .en_i         (vga.pix_en & h_wrap),
    .count_o      (v_q),
    .count_next_o (v_next),
    .wrap_o       (v_wrap)
  );

  logic hsync_q,       hsync_d;
  logic vsync_q,       vsync_d;
  logic video_on_q,    video_on_d;
  logic line_end_q,    line_end_d;
  logic frame_start_q, frame_start_d;

  // Decode the next counter values so the registered levels line up with the counts.
  always_comb begin
    hsync_d       = ~HSYNC_POL;
    vsync_d       = ~VSYNC_POL;
    video_on_d    = 1'b0;
    line_end_d    = 1'b0;
    frame_start_d = 1'b0;
    if ((h_next >= HS_START) && (h_next < HS_END)) begin
      hsync_d = HSYNC_POL;
    end
    if ((v_next >= VS_START) && (v_next < VS_END)) begin
      vsync_d = VSYNC_POL;
    end
    video_on_d    = (h_next < H_ACT) && (v_next < V_ACT);
    line_end_d    = vga.pix_en && (h_next == H_LAST);
    frame_start_d = h_wrap && v_wrap;
  end

  always_ff @(posedge clk_25MHz or negedge reset_n) begin
    if (!reset_n) begin
      hsync_q       <= ~HSYNC_POL;
      vsync_q       <= ~VSYNC_POL;
      video_on_q    <= 1'b1;
      line_end_q    <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      line_end_q    <= line_end_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign vga.h_count_value = h_q;
  assign vga.v_count_value = v_q;
  assign vga.hsync         = hsync_q;
  assign vga.vsync         = vsync_q;
  assign vga.video_on      = video_on_q;
  assign vga.line_end      = line_end_q;
  assign vga.frame_start   = frame_start_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// tb_vga_timing_gen : three modes checked against an arithmetic frame model. rev 1.0
// ============================================================================
module tb_vga_timing_gen;
  import vga_timing_pkg::*;

  localparam vga_mode_t M_DEF   = VGA_640X480_60;
  localparam vga_mode_t M_SMALL = '{h_active: 4, h_front: 1, h_sync: 1, h_back: 1,
                                    v_active: 2, v_front: 1, v_sync: 1, v_back: 1};
  localparam vga_mode_t M_MED   = '{h_active: 8, h_front: 2, h_sync: 3, h_back: 2,
                                    v_active: 4, v_front: 2, v_sync: 2, v_back: 2};

  typedef struct packed {
    logic [15:0] h;
    logic [15:0] v;
    logic        hs;
    logic        vs;
    logic        vid;
    logic        le;
    logic        fs;
  } out_t;

  typedef struct packed {
    bit       en;
    int       h;
    int       v;
    bit       hs;
    bit       vs;
    bit       vid;
    bit       le;
    bit       fs;
  } row_t;

  logic       clk = 1'b0;
  logic [2:0] rn  = 3'b000;
  logic [2:0] pe  = 3'b000;
  out_t       act [3];

  vga_mode_t  modes [3];
  bit         hpol  [3];
  bit         vpol  [3];
  string      nm    [3];
  longint     n     [3];
  bit         last_en [3];

  int errors   = 0;
  int n_checks = 0;

  always #5 clk = ~clk;

  vga_timing_gen_if #(.COUNT_W(16)) if0 ();
  vga_timing_gen_if #(.COUNT_W(16)) if1 ();
  vga_timing_gen_if #(.COUNT_W(16)) if2 ();

  assign if0.pix_en = pe[0];
  assign if1.pix_en = pe[1];
  assign if2.pix_en = pe[2];

  assign act[0] = {if0.h_count_value, if0.v_count_value, if0.hsync, if0.vsync,
                   if0.video_on, if0.line_end, if0.frame_start};
  assign act[1] = {if1.h_count_value, if1.v_count_value, if1.hsync, if1.vsync,
                   if1.video_on, if1.line_end, if1.frame_start};
  assign act[2] = {if2.h_count_value, if2.v_count_value, if2.hsync, if2.vsync,
                   if2.video_on, if2.line_end, if2.frame_start};

  vga_timing_gen #(
    .H_ACTIVE(M_DEF.h_active), .H_FRONT(M_DEF.h_front), .H_SYNC(M_DEF.h_sync), .H_BACK(M_DEF.h_back),
    .V_ACTIVE(M_DEF.v_active), .V_FRONT(M_DEF.v_front), .V_SYNC(M_DEF.v_sync), .V_BACK(M_DEF.v_back),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .COUNT_W(16)
  ) u_def (.clk_25MHz(clk), .reset_n(rn[0]), .vga(if0));

  vga_timing_gen #(
    .H_ACTIVE(M_SMALL.h_active), .H_FRONT(M_SMALL.h_front), .H_SYNC(M_SMALL.h_sync), .H_BACK(M_SMALL.h_back),
    .V_ACTIVE(M_SMALL.v_active), .V_FRONT(M_SMALL.v_front), .V_SYNC(M_SMALL.v_sync), .V_BACK(M_SMALL.v_back),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .COUNT_W(16)
  ) u_small (.clk_25MHz(clk), .reset_n(rn[1]), .vga(if1));

  vga_timing_gen #(
    .H_ACTIVE(M_MED.h_active), .H_FRONT(M_MED.h_front), .H_SYNC(M_MED.h_sync), .H_BACK(M_MED.h_back),
    .V_ACTIVE(M_MED.v_active), .V_FRONT(M_MED.v_front), .V_SYNC(M_MED.v_sync), .V_BACK(M_MED.v_back),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .COUNT_W(16)
  ) u_med (.clk_25MHz(clk), .reset_n(rn[2]), .vga(if2));

  // Position is a pure function of the number of enabled pixel clocks since reset.
  function automatic out_t model(input vga_mode_t m, input bit hp, input bit vp,
                                 input longint cnt, input bit en_prev);
    out_t   o;
    longint ht, vt, h, v, hs0, vs0;
    ht  = longint'(m.h_active) + m.h_front + m.h_sync + m.h_back;
    vt  = longint'(m.v_active) + m.v_front + m.v_sync + m.v_back;
    h   = cnt % ht;
    v   = (cnt / ht) % vt;
    hs0 = longint'(m.h_active) + m.h_front;
    vs0 = longint'(m.v_active) + m.v_front;
    o.h   = 16'(h);
    o.v   = 16'(v);
    o.hs  = (h >= hs0 && h < hs0 + m.h_sync) ? hp : !hp;
    o.vs  = (v >= vs0 && v < vs0 + m.v_sync) ? vp : !vp;
    o.vid = (h < m.h_active) && (v < m.v_active);
    o.le  = en_prev && (h == ht - 1);
    o.fs  = en_prev && (cnt > 0) && ((cnt % (ht * vt)) == 0);
    return o;
  endfunction

  task automatic chk(input string name, input logic [63:0] a, input logic [63:0] e);
    n_checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, a, e);
    end
  endtask

  task automatic compare(input int k, input string tag);
    out_t e;
    string p;
    e = model(modes[k], hpol[k], vpol[k], n[k], last_en[k]);
    p = $sformatf("%s/%s n=%0d", nm[k], tag, n[k]);
    chk({p, " h"},           act[k].h,   e.h);
    chk({p, " v"},           act[k].v,   e.v);
    chk({p, " hsync"},       act[k].hs,  e.hs);
    chk({p, " vsync"},       act[k].vs,  e.vs);
    chk({p, " video_on"},    act[k].vid, e.vid);
    chk({p, " line_end"},    act[k].le,  e.le);
    chk({p, " frame_start"}, act[k].fs,  e.fs);
  endtask

  // Called #1 after a rising edge; returns #1 after the next one.
  task automatic step(input int k, input bit en);
    pe    = 3'b000;
    pe[k] = en;
    @(posedge clk);
    #1;
    n[k]       = n[k] + (en ? 1 : 0);
    last_en[k] = en;
  endtask

  task automatic areset(input int k);
    pe = 3'b000;
    #3;
    rn[k] = 1'b0;
    #1;
    n[k]       = 0;
    last_en[k] = 1'b0;
    compare(k, "async_rst");
    @(posedge clk);
    #1;
    compare(k, "in_rst");
    rn[k] = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    row_t tbl [11];
    int   fs_cnt, fs_first, vid_cnt;

    modes[0] = M_DEF;   hpol[0] = 1'b0; vpol[0] = 1'b0; nm[0] = "def";
    modes[1] = M_SMALL; hpol[1] = 1'b0; vpol[1] = 1'b0; nm[1] = "small";
    modes[2] = M_MED;   hpol[2] = 1'b1; vpol[2] = 1'b1; nm[2] = "med_pol";
    for (int k = 0; k < 3; k++) begin
      n[k] = 0;
      last_en[k] = 1'b0;
    end

    // Small mode 7x5: hsync low at h=5, vsync low at v=3, active h<4 && v<2.
    tbl[0]  = '{1'b1, 1, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 2, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 3, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 4, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 5, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 5, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 6, 0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 6, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 0, 1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 1, 1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) compare(k, "reset");
    rn = 3'b111;

    for (int i = 0; i < 11; i++) begin
      string p;
      step(1, tbl[i].en);
      p = $sformatf("small/table row %0d", i);
      chk({p, " h"},           act[1].h,   16'(tbl[i].h));
      chk({p, " v"},           act[1].v,   16'(tbl[i].v));
      chk({p, " hsync"},       act[1].hs,  tbl[i].hs);
      chk({p, " vsync"},       act[1].vs,  tbl[i].vs);
      chk({p, " video_on"},    act[1].vid, tbl[i].vid);
      chk({p, " line_end"},    act[1].le,  tbl[i].le);
      chk({p, " frame_start"}, act[1].fs,  tbl[i].fs);
    end

    // Two full small frames: frame_start every 35 enabled cycles, 8 active pixels per frame.
    areset(1);
    fs_cnt = 0; fs_first = -1; vid_cnt = 0;
    for (int i = 1; i <= 70; i++) begin
      step(1, 1'b1);
      compare(1, "frames");
      if (act[1].fs === 1'b1) begin
        fs_cnt++;
        if (fs_first < 0) fs_first = i;
      end
      if (i <= 35 && act[1].vid === 1'b1) vid_cnt++;
    end
    chk("small frame_start count", 64'(fs_cnt), 64'd2);
    chk("small frame_start first", 64'(fs_first), 64'd35);
    chk("small video_on per frame", 64'(vid_cnt), 64'd8);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) areset(1);
      step(1, 1'($urandom_range(0, 3) != 0));
      compare(1, "rand");
    end

    // Default mode: first lines at full rate, then async reset while hsync is asserted.
    for (int i = 0; i < 2300; i++) begin
      step(0, 1'b1);
      compare(0, "run");
    end
    chk("def hsync asserted at (700,2)", act[0].hs, 1'b0);
    areset(0);
    for (int i = 0; i < 1200; i++) begin
      step(0, 1'($urandom_range(0, 1)));
      compare(0, "rand");
    end

    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 399) == 0) areset(2);
      step(2, 1'($urandom_range(0, 3) != 0));
      compare(2, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
